// File: rtl/la_pkg.sv
// Shared types and helpers for the channel readout arbiter.
package la_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } arb_state_t;

  // Ceiling log2, used for derived counter and tag widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requester at or after ptr, wrapping.
module rr_picker
  import la_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int ID_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_any
);

  logic [ID_W-1:0] idx;

  // Walk the channels starting at ptr and keep the first one requesting.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_CH);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Drains per-channel sample FIFOs into one tagged word stream, round-robin
// with a bounded burst per grant.
//
// state   | meaning
// IDLE    | no grant; picks next available channel when enabled
// STROBE  | ch_read high for the granted channel (one cycle)
// WAIT    | FIFO read latency, RD_LAT-1 cycles
// CAPTURE | FIFO q valid; load output register
// HOLD    | o_valid high until the sink takes the word
// GAP     | ch_read low one cycle; continue burst or release grant
module channel_readout_arbiter
  import la_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int RD_LAT = 3,
  parameter  int BURST  = 8,
  localparam int ID_W   = clog2(N_CH)
) (
  input  logic                   i_clk,
  input  logic                   _mrst,
  input  logic                   enable,
  input  logic [N_CH-1:0]        ch_available,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  output logic [N_CH-1:0]        ch_read,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [DATA_W-1:0]      o_data,
  output logic [ID_W-1:0]        o_ch,
  output logic                   busy
);

  localparam int LAT_W   = clog2(RD_LAT + 1);
  localparam int BURST_W = clog2(BURST + 1);
  localparam logic [LAT_W-1:0]   LAT_LOAD  = LAT_W'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);
  localparam logic [ID_W-1:0]    ID_LAST   = ID_W'(N_CH - 1);

  arb_state_t state_q, state_nxt;

  logic [ID_W-1:0]    grant_q, grant_nxt;
  logic [ID_W-1:0]    ptr_q, ptr_nxt;
  logic [BURST_W-1:0] burst_q, burst_nxt;
  logic [LAT_W-1:0]   lat_q, lat_nxt;
  logic [N_CH-1:0]    read_nxt;
  logic               valid_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic [ID_W-1:0]    ch_nxt;

  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [DATA_W-1:0]  ch_word [N_CH];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_word[k] = ch_data[k*DATA_W +: DATA_W];
  end

  rr_picker #(.N_CH(N_CH)) u_picker (
    .req     (ch_available),
    .ptr     (ptr_q),
    .gnt_id  (pick_id),
    .gnt_any (pick_any)
  );

  // State register.
  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state decode; availability only matters in IDLE and GAP.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable && pick_any) state_nxt = ST_STROBE;
      ST_STROBE:  state_nxt = (RD_LAT == 1) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:    if (lat_q == '0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_HOLD;
      ST_HOLD:    if (o_ready) state_nxt = ST_GAP;
      ST_GAP: begin
        if (enable && ch_available[grant_q] && (burst_q < BURST_MAX)) state_nxt = ST_STROBE;
        else                                                           state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, latency timer and burst/pointer state.
  always_comb begin
    grant_nxt = grant_q;
    ptr_nxt   = ptr_q;
    burst_nxt = burst_q;
    lat_nxt   = lat_q;
    valid_nxt = o_valid;
    data_nxt  = o_data;
    ch_nxt    = o_ch;
    read_nxt  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (state_nxt == ST_STROBE) begin
          grant_nxt = pick_id;
          burst_nxt = '0;
        end
      end
      ST_STROBE: lat_nxt = LAT_LOAD;
      ST_WAIT:   if (lat_q != '0) lat_nxt = lat_q - LAT_W'(1);
      ST_CAPTURE: begin
        data_nxt  = ch_word[grant_q];
        ch_nxt    = grant_q;
        valid_nxt = 1'b1;
      end
      ST_HOLD: begin
        if (o_ready) begin
          valid_nxt = 1'b0;
          burst_nxt = burst_q + BURST_W'(1);
        end
      end
      ST_GAP: begin
        if (state_nxt == ST_IDLE) ptr_nxt = (grant_q == ID_LAST) ? '0 : grant_q + ID_W'(1);
      end
      default: ;
    endcase
    if (state_nxt == ST_STROBE) read_nxt[grant_nxt] = 1'b1;
  end

  // Output register and datapath state.
  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      lat_q   <= '0;
      ch_read <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      busy    <= 1'b0;
    end else begin
      grant_q <= grant_nxt;
      ptr_q   <= ptr_nxt;
      burst_q <= burst_nxt;
      lat_q   <= lat_nxt;
      ch_read <= read_nxt;
      o_valid <= valid_nxt;
      o_data  <= data_nxt;
      o_ch    <= ch_nxt;
      busy    <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Bench for channel_readout_arbiter: two instances (BURST=8 and BURST=1)
// fed by behavioural channel FIFOs with an RD_LAT-cycle read latency.
module tb_channel_readout_arbiter;

  localparam int N_CH   = 4;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic               mrst;
  logic               enable_a, enable_b, ready_a, ready_b;
  logic [N_CH-1:0]    avail_a, avail_b, read_a, read_b;
  logic [N_CH*DW-1:0] data_a, data_b;
  logic               valid_a, valid_b, busy_a, busy_b;
  logic [DW-1:0]      odata_a, odata_b;
  logic [1:0]         och_a, och_b;

  channel_readout_arbiter #(.N_CH(N_CH), .DATA_W(DW), .RD_LAT(RD_LAT), .BURST(8)) dut_a (
    .i_clk(i_clk), ._mrst(mrst), .enable(enable_a), .ch_available(avail_a),
    .ch_data(data_a), .ch_read(read_a), .o_valid(valid_a), .o_ready(ready_a),
    .o_data(odata_a), .o_ch(och_a), .busy(busy_a));

  channel_readout_arbiter #(.N_CH(N_CH), .DATA_W(DW), .RD_LAT(RD_LAT), .BURST(1)) dut_b (
    .i_clk(i_clk), ._mrst(mrst), .enable(enable_b), .ch_available(avail_b),
    .ch_data(data_b), .ch_read(read_b), .o_valid(valid_b), .o_ready(ready_b),
    .o_data(odata_b), .o_ch(och_b), .busy(busy_b));

  // Channel FIFO model: wr side owned by the stimulus, rd side by the model.
  logic [31:0] mem [2][N_CH][64];
  int          wr [2][N_CH];
  int          rd [2][N_CH];
  int          cd [2][N_CH];
  logic [31:0] pend [2][N_CH];
  logic [31:0] dq [2][N_CH];
  logic        prev_rd [2][N_CH];
  int          cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // q is only valid during the cycle RD_LAT after the strobe rose; garbage otherwise.
  always @(negedge i_clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!mrst) begin
          rd[i][k]      = wr[i][k];
          cd[i][k]      = 0;
          prev_rd[i][k] = 1'b0;
          dq[i][k]      = 32'hBAD0_0000;
        end else begin
          dq[i][k] = 32'hBAD0_0000 | 32'(k);
          if (cd[i][k] != 0) begin
            cd[i][k] = cd[i][k] - 1;
            if (cd[i][k] == 0) dq[i][k] = pend[i][k];
          end
          if (((i == 0) ? read_a[k] : read_b[k]) && !prev_rd[i][k]) begin
            pend[i][k] = mem[i][k][rd[i][k] % 64];
            rd[i][k]   = rd[i][k] + 1;
            cd[i][k]   = RD_LAT;
          end
          prev_rd[i][k] = (i == 0) ? read_a[k] : read_b[k];
        end
      end
    end
  end

  always_comb begin
    avail_a = '0;
    avail_b = '0;
    data_a  = '0;
    data_b  = '0;
    for (int k = 0; k < N_CH; k++) begin
      avail_a[k]          = (wr[0][k] != rd[0][k]);
      avail_b[k]          = (wr[1][k] != rd[1][k]);
      data_a[k*DW +: DW]  = dq[0][k];
      data_b[k*DW +: DW]  = dq[1][k];
    end
  end

  // Monitor: accepted words, strobe rises, protocol violations, strobe-to-valid latency.
  logic [33:0] acc_a [$];
  logic [33:0] acc_b [$];
  int          rise_a [$];
  int          pulses_a = 0;
  int          viol_a = 0;
  int          lat_a = 0;
  logic        prev_read_a_nz = 1'b0;
  logic        prev_valid_a = 1'b0;

  always @(negedge i_clk) begin
    if (valid_a && ready_a) acc_a.push_back({och_a, odata_a});
    if (valid_b && ready_b) acc_b.push_back({och_b, odata_b});
    if (read_a != '0 && !prev_read_a_nz) begin
      pulses_a = pulses_a + 1;
      rise_a.push_back(cyc);
    end
    if (read_a != '0 && prev_read_a_nz) viol_a = viol_a + 1;
    if (!$onehot0(read_a)) viol_a = viol_a + 1;
    if (read_a != '0 && valid_a) viol_a = viol_a + 1;
    if (valid_a && !prev_valid_a && rise_a.size() > 0) lat_a = cyc - rise_a[rise_a.size()-1];
    prev_read_a_nz = (read_a != '0);
    prev_valid_a   = valid_a;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic push(input int i, input int k, input logic [31:0] w);
    mem[i][k][wr[i][k] % 64] = w;
    wr[i][k] = wr[i][k] + 1;
  endtask

  function automatic int acc_size(input int i);
    return (i == 0) ? acc_a.size() : acc_b.size();
  endfunction

  function automatic logic [33:0] get_w(input int i, input int idx);
    if (i == 0) return (idx < acc_a.size()) ? acc_a[idx] : '1;
    return (idx < acc_b.size()) ? acc_b[idx] : '1;
  endfunction

  task automatic wait_acc(input int i, input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (acc_size(i) < n && k < budget) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    chk({nm, " word count"}, 64'(acc_size(i)), 64'(n));
  endtask

  task automatic wait_idle_a(input int budget, input string nm);
    int k;
    k = 0;
    while (busy_a && k < budget) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    chk({nm, " busy"}, 64'(busy_a), 64'(0));
  endtask

  typedef struct {
    int          ch;
    logic [31:0] word;
    logic [1:0]  exp_ch;
    logic [31:0] exp_data;
    int          exp_lat;
  } single_vec_t;

  typedef struct {
    logic [1:0]  exp_ch;
    logic [31:0] exp_data;
  } out_vec_t;

  single_vec_t sv_tab [4];
  out_vec_t    rr_tab [6];

  initial begin
    int base, p0, v0, r0, k, mg, unstable;
    logic [31:0] d0;
    logic [1:0]  c0;
    logic [33:0] exp_w;

    sv_tab[0] = '{ch: 2, word: 32'hDEADBEEF, exp_ch: 2'd2, exp_data: 32'hDEADBEEF, exp_lat: 4};
    sv_tab[1] = '{ch: 3, word: 32'hFFFFFFFF, exp_ch: 2'd3, exp_data: 32'hFFFFFFFF, exp_lat: 4};
    sv_tab[2] = '{ch: 1, word: 32'h00000001, exp_ch: 2'd1, exp_data: 32'h00000001, exp_lat: 4};
    sv_tab[3] = '{ch: 0, word: 32'h12345678, exp_ch: 2'd0, exp_data: 32'h12345678, exp_lat: 4};

    rr_tab[0] = '{exp_ch: 2'd0, exp_data: 32'h000000A0};
    rr_tab[1] = '{exp_ch: 2'd1, exp_data: 32'h000000B0};
    rr_tab[2] = '{exp_ch: 2'd3, exp_data: 32'h000000D0};
    rr_tab[3] = '{exp_ch: 2'd0, exp_data: 32'h000000A1};
    rr_tab[4] = '{exp_ch: 2'd1, exp_data: 32'h000000B1};
    rr_tab[5] = '{exp_ch: 2'd3, exp_data: 32'h000000D1};

    mrst = 1'b0;
    enable_a = 1'b0;
    enable_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    cycles(3);
    chk("reset ch_read", 64'(read_a), 64'(0));
    chk("reset o_valid", 64'(valid_a), 64'(0));
    chk("reset o_data", 64'(odata_a), 64'(0));
    chk("reset o_ch", 64'(och_a), 64'(0));
    chk("reset busy", 64'(busy_a), 64'(0));
    mrst = 1'b1;

    // Enabled with nothing available: stays idle.
    enable_a = 1'b1;
    cycles(5);
    chk("idle empty busy", 64'(busy_a), 64'(0));
    chk("idle empty pulses", 64'(pulses_a), 64'(0));

    // Single words from one channel at a time.
    for (int t = 0; t < 4; t++) begin
      base = acc_a.size();
      p0   = pulses_a;
      push(0, sv_tab[t].ch, sv_tab[t].word);
      wait_acc(0, base + 1, 40, "single");
      chk("single word", 64'(get_w(0, base)), 64'({sv_tab[t].exp_ch, sv_tab[t].exp_data}));
      chk("single latency", 64'(lat_a), 64'(sv_tab[t].exp_lat));
      chk("single pulses", 64'(pulses_a - p0), 64'(1));
      wait_idle_a(20, "single idle");
    end

    // Rotation with BURST=1 on the second instance.
    push(1, 0, 32'hA0); push(1, 0, 32'hA1);
    push(1, 1, 32'hB0); push(1, 1, 32'hB1);
    push(1, 3, 32'hD0); push(1, 3, 32'hD1);
    enable_b = 1'b1;
    wait_acc(1, 6, 120, "rr");
    for (int i = 0; i < 6; i++)
      chk("rr order", 64'(get_w(1, i)), 64'({rr_tab[i].exp_ch, rr_tab[i].exp_data}));
    enable_b = 1'b0;

    // Burst: pointer is at ch1, ch1 has 20 words, ch0 has one.
    base = acc_a.size();
    r0   = rise_a.size();
    v0   = viol_a;
    for (int i = 0; i < 20; i++) push(0, 1, 32'h1000 + 32'(i));
    push(0, 0, 32'h0AAA);
    wait_acc(0, base + 21, 400, "burst");
    for (int j = 0; j < 21; j++) begin
      if (j < 8)       exp_w = {2'd1, 32'h1000 + 32'(j)};
      else if (j == 8) exp_w = {2'd0, 32'h0AAA};
      else             exp_w = {2'd1, 32'h1000 + 32'(j - 1)};
      chk("burst order", 64'(get_w(0, base + j)), 64'(exp_w));
    end
    mg = 1000;
    for (int i = r0 + 1; i < rise_a.size(); i++)
      if (rise_a[i] - rise_a[i-1] < mg) mg = rise_a[i] - rise_a[i-1];
    chk("burst strobe spacing", 64'(mg), 64'(RD_LAT + 3));
    chk("burst protocol", 64'(viol_a - v0), 64'(0));
    wait_idle_a(20, "burst idle");

    // Backpressure in HOLD with more data waiting on the same channel.
    ready_a = 1'b0;
    base = acc_a.size();
    push(0, 2, 32'hCAFE0001);
    push(0, 2, 32'hCAFE0002);
    k = 0;
    while (!valid_a && k < 40) begin
      cycles(1);
      k++;
    end
    chk("bp valid", 64'(valid_a), 64'(1));
    d0 = odata_a;
    c0 = och_a;
    p0 = pulses_a;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (!valid_a || odata_a !== d0 || och_a !== c0) unstable++;
    end
    chk("bp stable", 64'(unstable), 64'(0));
    chk("bp held word", 64'({c0, d0}), 64'({2'd2, 32'hCAFE0001}));
    chk("bp no strobe", 64'(pulses_a - p0), 64'(0));
    chk("bp no accept", 64'(acc_a.size()), 64'(base));
    ready_a = 1'b1;
    cycles(2);
    chk("bp accepted once", 64'(acc_a.size()), 64'(base + 1));
    wait_acc(0, base + 2, 40, "bp");
    chk("bp word 1", 64'(get_w(0, base)), 64'({2'd2, 32'hCAFE0001}));
    chk("bp word 2", 64'(get_w(0, base + 1)), 64'({2'd2, 32'hCAFE0002}));
    wait_idle_a(20, "bp idle");

    // Enable dropped while waiting on the FIFO latency.
    base = acc_a.size();
    push(0, 3, 32'h5A5A0000);
    push(0, 3, 32'h5A5A0001);
    push(0, 3, 32'h5A5A0002);
    k = 0;
    while (read_a == '0 && k < 20) begin
      cycles(1);
      k++;
    end
    chk("drop strobe seen", 64'(read_a), 64'(4'b1000));
    cycles(1);
    enable_a = 1'b0;
    wait_acc(0, base + 1, 30, "drop");
    chk("drop word", 64'(get_w(0, base)), 64'({2'd3, 32'h5A5A0000}));
    wait_idle_a(10, "drop idle");
    p0 = pulses_a;
    cycles(20);
    chk("drop no strobe", 64'(pulses_a - p0), 64'(0));
    chk("drop still idle", 64'(busy_a), 64'(0));
    chk("drop avail kept", 64'(avail_a[3]), 64'(1));

    // Asynchronous reset while holding a word.
    ready_a  = 1'b0;
    enable_a = 1'b1;
    k = 0;
    while (!valid_a && k < 30) begin
      cycles(1);
      k++;
    end
    chk("rst pre word", 64'({och_a, odata_a}), 64'({2'd3, 32'h5A5A0001}));
    mrst = 1'b0;
    #1;
    chk("rst o_valid", 64'(valid_a), 64'(0));
    chk("rst o_data", 64'(odata_a), 64'(0));
    chk("rst o_ch", 64'(och_a), 64'(0));
    chk("rst busy", 64'(busy_a), 64'(0));
    chk("rst ch_read", 64'(read_a), 64'(0));
    cycles(1);
    mrst = 1'b1;
    ready_a = 1'b1;
    p0 = pulses_a;
    cycles(10);
    chk("post rst busy", 64'(busy_a), 64'(0));
    chk("post rst no strobe", 64'(pulses_a - p0), 64'(0));
    chk("post rst o_valid", 64'(valid_a), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
